// File: rtl/reg_file_mp.sv
// Multi-ported register file: two write ports, NUM_RD registered read ports,
// optional hard-wired zero register and selectable read/write collision mode.
module reg_file_mp #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 5,
  parameter int NUM_RD      = 2,
  parameter int ZERO_REG    = 1,
  parameter int WRITE_FIRST = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     RegWrite0,
  input  logic [ADDR_W-1:0]        WriteReg0,
  input  logic [DATA_W-1:0]        WriteData0,
  input  logic                     RegWrite1,
  input  logic [ADDR_W-1:0]        WriteReg1,
  input  logic [DATA_W-1:0]        WriteData1,
  input  logic [NUM_RD*ADDR_W-1:0] ReadReg,
  output logic [NUM_RD*DATA_W-1:0] ReadData,
  output logic                     WriteConflict
);

  localparam int  DEPTH = 1 << ADDR_W;
  localparam bit  ZR_EN = (ZERO_REG != 32'sd0);
  localparam bit  WF_EN = (WRITE_FIRST != 32'sd0);

  logic [DATA_W-1:0] r_mem   [DEPTH];
  logic [DATA_W-1:0] r_rdata [NUM_RD];
  logic              r_conflict;

  logic              w_we0;
  logic              w_we1;
  logic              w_conflict;
  logic              w_commit0;
  logic [ADDR_W-1:0] w_raddr [NUM_RD];
  logic [DATA_W-1:0] w_rdata [NUM_RD];

  function automatic logic is_zero_reg(input logic [ADDR_W-1:0] addr);
    return ZR_EN && (addr == {ADDR_W{1'b0}});
  endfunction

  // Effective write enables; writes to the hard-wired zero register never count.
  always_comb begin
    w_we0      = RegWrite0 && !is_zero_reg(WriteReg0);
    w_we1      = RegWrite1 && !is_zero_reg(WriteReg1);
    w_conflict = w_we0 && w_we1 && (WriteReg0 == WriteReg1);
    w_commit0  = w_we0 && !w_conflict;
  end

  // Per-port read mux with optional write-first bypass, port 1 taking priority.
  always_comb begin
    for (int k = 0; k < NUM_RD; k++) begin
      w_raddr[k] = ReadReg[k*ADDR_W +: ADDR_W];
      if (is_zero_reg(w_raddr[k])) begin
        w_rdata[k] = {DATA_W{1'b0}};
      end else if (WF_EN && w_we1 && (w_raddr[k] == WriteReg1)) begin
        w_rdata[k] = WriteData1;
      end else if (WF_EN && w_commit0 && (w_raddr[k] == WriteReg0)) begin
        w_rdata[k] = WriteData0;
      end else begin
        w_rdata[k] = r_mem[w_raddr[k]];
      end
    end
  end

  // Register storage; port 1 wins a same-address collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= {DATA_W{1'b0}};
      end
    end else begin
      if (w_commit0) begin
        r_mem[WriteReg0] <= WriteData0;
      end
      if (w_we1) begin
        r_mem[WriteReg1] <= WriteData1;
      end
    end
  end

  // Registered read data and conflict flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_RD; k++) begin
        r_rdata[k] <= {DATA_W{1'b0}};
      end
      r_conflict <= 1'b0;
    end else begin
      for (int k = 0; k < NUM_RD; k++) begin
        r_rdata[k] <= w_rdata[k];
      end
      r_conflict <= w_conflict;
    end
  end

  // Pack the read-data registers onto the output bus.
  always_comb begin
    ReadData = {(NUM_RD*DATA_W){1'b0}};
    for (int k = 0; k < NUM_RD; k++) begin
      ReadData[k*DATA_W +: DATA_W] = r_rdata[k];
    end
  end

  assign WriteConflict = r_conflict;

endmodule

// File: doc/reg_file_mp.md
REG_FILE_MP -- requirements
Module: reg_file_mp

Interface
REQ-001 Parameter DATA_W, default 32: register width in bits.
REQ-002 Parameter ADDR_W, default 5: register address width; depth is 2**ADDR_W.
REQ-003 Parameter NUM_RD, default 2: number of read ports, range 1..4.
REQ-004 Parameter ZERO_REG, default 1: when 1, register 0 reads as 0 and ignores writes; when 0, register 0 is an ordinary register.
REQ-005 Parameter WRITE_FIRST, default 1: same-cycle read/write collision mode; 1 returns new data, 0 returns old data.
REQ-006 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-007 Port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-008 Port RegWrite0, input, 1 bit: write port 0 enable.
REQ-009 Port WriteReg0, input, ADDR_W bits: write port 0 address.
REQ-010 Port WriteData0, input, DATA_W bits: write port 0 data.
REQ-011 Port RegWrite1, input, 1 bit: write port 1 enable.
REQ-012 Port WriteReg1, input, ADDR_W bits: write port 1 address.
REQ-013 Port WriteData1, input, DATA_W bits: write port 1 data.
REQ-014 Port ReadReg, input, NUM_RD*ADDR_W bits: packed read addresses; port k uses slice [k*ADDR_W +: ADDR_W].
REQ-015 Port ReadData, output, NUM_RD*DATA_W bits: packed registered read data; port k uses slice [k*DATA_W +: DATA_W].
REQ-016 Port WriteConflict, output, 1 bit: registered flag, high for one cycle after both write ports targeted the same writable register.

Function
REQ-017 Storage shall be 2**ADDR_W registers of DATA_W bits.
REQ-018 Read latency shall be exactly 1 cycle: ReadData slice k after edge N reflects ReadReg slice k sampled at edge N.
REQ-019 All NUM_RD read ports shall operate independently and simultaneously, including when they use identical addresses.
REQ-020 A write port shall update its register at the rising edge only while its RegWrite is 1.
REQ-021 Both write ports shall commit in the same cycle when their addresses differ.
REQ-022 When both write ports hit the same address, port 1 data shall be stored, port 0 data dropped, and WriteConflict shall be 1 in the following cycle.
REQ-023 A write to register 0 with ZERO_REG=1 shall have no effect, and shall not raise WriteConflict.
REQ-024 A read of register 0 with ZERO_REG=1 shall return 0 regardless of the collision mode.
REQ-025 With WRITE_FIRST=1, a read whose address equals an active write address in the same cycle shall return the write data, with port 1 priority per REQ-022.
REQ-026 With WRITE_FIRST=0, a read whose address equals an active write address in the same cycle shall return the pre-write content.
REQ-027 Out-of-range behaviour shall not exist: every ADDR_W address value is valid.
REQ-028 Blocking/nonblocking ordering shall not influence results; REQ-025 and REQ-026 are the only collision semantics.

Reset
REQ-029 While rst_n=0, all registers, all ReadData slices and WriteConflict shall be 0, immediately and without waiting for a clock edge.
REQ-030 Writes presented while rst_n=0 shall be discarded.
REQ-031 The first rising edge with rst_n=1 shall perform normal reads and writes.
REQ-032 Reset asserted mid-operation shall clear state within the same cycle; a write at the edge where rst_n rises is honoured.

Verification
REQ-033 Scenario 1: after reset, write 0xDEADBEEF to r5 via port 0, then read r5 on ports 0 and 1 next cycle -> both ReadData slices equal 0xDEADBEEF one cycle later.
REQ-034 Scenario 2: same cycle, port 0 writes 0x11111111 and port 1 writes 0x22222222 to r7 -> r7=0x22222222 and WriteConflict=1 for exactly one cycle.
REQ-035 Scenario 3: ZERO_REG=1, write 0xFFFFFFFF to r0 via port 1 and read r0 -> ReadData 0 and WriteConflict 0.
REQ-036 Scenario 4: r3=0xA5A5A5A5, same cycle write 0x5A5A5A5A to r3 and read r3 -> WRITE_FIRST=1 returns 0x5A5A5A5A; WRITE_FIRST=0 returns 0xA5A5A5A5.
REQ-037 Scenario 5: fill r1..r31 with index values, drop rst_n mid-cycle -> all outputs 0 before the next edge; a read of r31 after release returns 0.
REQ-038 Scenario 6: NUM_RD=4, DATA_W=16, ADDR_W=3, then random writes and reads compared to a reference model for 10000 cycles -> zero mismatches.
